// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer.
package scan_pkg;

   localparam int NUM_LINES         = 16;
   localparam int BLANK_CYC_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

endpackage

// File: rtl/scan_next_line.sv
// Combinational priority search over the line mask: the lowest enabled line
// strictly above cur_idx, and the lowest enabled line overall.
module scan_next_line
   import scan_pkg::*;
(
   input  logic [3:0]           cur_idx,
   input  logic [NUM_LINES-1:0] mask,
   output logic [3:0]           next_idx,
   output logic                 has_next,
   output logic [3:0]           first_idx,
   output logic                 any_en
);

   // Scan from the top line down so the lowest qualifying line is written last.
   // The search never wraps: nothing lies above line 15.
   always_comb begin
      next_idx  = 4'd0;
      has_next  = 1'b0;
      first_idx = 4'd0;
      any_en    = 1'b0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first_idx = 4'(i);
            any_en    = 1'b1;
            if (i > int'(cur_idx)) begin
               next_idx = 4'(i);
               has_next = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Sequential driver for a 4-to-16 line decoder: steps sel through the enabled
// lines, blanking en while sel changes and holding each line for a dwell time.
// Optional feature macro: SCAN_SEQ_MASK_EN adds the line_mask port; without it
// the mask is tied to all-ones and the successor search folds to an increment.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | not scanning, sel = 0, en = 0; waits for start
// BLANK  | sel holds the chosen line, en = 0 for BLANK_CYC cycles
// ACTIVE | en = 1 for max(dwell, 1) cycles, then pick next line or stop
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_W   = 8,
   parameter int BLANK_CYC = BLANK_CYC_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SEQ_MASK_EN
   input  logic [NUM_LINES-1:0] line_mask,
`endif
   output logic [3:0]         sel,
   output logic               en,
   output logic               busy,
   output logic               line_strobe,
   output logic               frame_done
);

   localparam logic [3:0]         BLANK_LOAD = 4'(BLANK_CYC - 1);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

   state_t             state_q, state_d;
   logic [3:0]         sel_q, sel_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               line_strobe_q, line_strobe_d;
   logic               frame_done_q, frame_done_d;
   logic               stop_q, stop_d;
   logic               mode_q, mode_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [3:0]         blank_cnt_q, blank_cnt_d;

   logic [NUM_LINES-1:0] mask;
   logic [3:0]           next_idx, first_idx;
   logic                 has_next, any_en;
   logic                 stop_now;
   logic [DWELL_W-1:0]   dwell_eff;

`ifdef SCAN_SEQ_MASK_EN
   assign mask = line_mask;
`else
   assign mask = '1;
`endif

   scan_next_line u_next_line (
      .cur_idx   (sel_q),
      .mask      (mask),
      .next_idx  (next_idx),
      .has_next  (has_next),
      .first_idx (first_idx),
      .any_en    (any_en)
   );

   // A stop arriving in the final ACTIVE cycle still ends scanning after this line.
   assign stop_now  = stop_q | stop;
   assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      stop_d        = stop_q;
      mode_d        = mode_q;
      dwell_cnt_d   = dwell_cnt_q;
      blank_cnt_d   = blank_cnt_q;
      line_strobe_d = 1'b0;
      frame_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (start && !stop && any_en) begin
               state_d     = BLANK;
               sel_d       = first_idx;
               mode_d      = mode;
               blank_cnt_d = BLANK_LOAD;
            end
         end
         BLANK: begin
            stop_d = stop_now;
            if (blank_cnt_q == 4'd0) begin
               state_d       = ACTIVE;
               dwell_cnt_d   = dwell_eff;
               line_strobe_d = 1'b1;
            end else begin
               blank_cnt_d = blank_cnt_q - 4'd1;
            end
         end
         ACTIVE: begin
            stop_d = stop_now;
            if (dwell_cnt_q <= DWELL_ONE) begin
               if (has_next && !stop_now) begin
                  state_d     = BLANK;
                  sel_d       = next_idx;
                  blank_cnt_d = BLANK_LOAD;
               end else begin
                  frame_done_d = !has_next;
                  if (!has_next && mode_q && !stop_now && any_en) begin
                     state_d     = BLANK;
                     sel_d       = first_idx;
                     blank_cnt_d = BLANK_LOAD;
                  end else begin
                     state_d = IDLE;
                     sel_d   = 4'd0;
                     stop_d  = 1'b0;
                  end
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = 4'd0;
            stop_d  = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
      en_d   = (state_d == ACTIVE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         sel_q         <= 4'd0;
         en_q          <= 1'b0;
         busy_q        <= 1'b0;
         line_strobe_q <= 1'b0;
         frame_done_q  <= 1'b0;
         stop_q        <= 1'b0;
         mode_q        <= 1'b0;
         dwell_cnt_q   <= '0;
         blank_cnt_q   <= 4'd0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         en_q          <= en_d;
         busy_q        <= busy_d;
         line_strobe_q <= line_strobe_d;
         frame_done_q  <= frame_done_d;
         stop_q        <= stop_d;
         mode_q        <= mode_d;
         dwell_cnt_q   <= dwell_cnt_d;
         blank_cnt_q   <= blank_cnt_d;
      end
   end

   assign sel         = sel_q;
   assign en          = en_q;
   assign busy        = busy_q;
   assign line_strobe = line_strobe_q;
   assign frame_done  = frame_done_q;

endmodule
